// File: rtl/montgomery_multiplier.sv
// Bit-serial (radix-2) Montgomery modular multiplier.
//   result = in_a * in_b * 2^-N mod in_m, fully reduced to 0 .. in_m-1.
// Flow: IDLE -> MULT (N cycles, one bit of A per cycle) -> REDUCE (2 cycles)
//       -> DONE (1 cycle, done pulse) -> IDLE. Fixed, data-independent latency.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous reset, active HIGH despite the name
//   start   level request, sampled only in IDLE
//   in_a    multiplicand A (< 2^N)
//   in_b    multiplicand B (< 2^N, may exceed M)
//   in_m    modulus M (odd, bit N-1 set)
//   result  registered A*B*2^-N mod M, held until the next completion
//   done    one-cycle completion pulse
module montgomery_multiplier #(
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MULT, REDUCE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_q, b_q, m_q;
  // C < B + M < 2^(N+1); adding B and M on top needs two extra bits.
  logic [N+1:0]    c_q;
  logic [N+1:0]    t_add, t_odd, c_red;
  logic            last_iter;

  always_comb begin
    t_add     = c_q + (a_q[0] ? {2'b00, b_q} : '0);
    // Adding odd M makes T even so the shift below is an exact divide by 2.
    t_odd     = t_add[0] ? (t_add + {2'b00, m_q}) : t_add;
    c_red     = (c_q >= {2'b00, m_q}) ? (c_q - {2'b00, m_q}) : c_q;
    last_iter = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (last_iter) state_nxt = REDUCE;
      REDUCE:  if (cnt[0]) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= in_a;
            b_q <= in_b;
            m_q <= in_m;
            c_q <= '0;
            cnt <= '0;
          end
        end
        MULT: begin
          // A is consumed LSB first by shifting it down.
          a_q <= a_q >> 1;
          c_q <= t_odd >> 1;
          cnt <= last_iter ? '0 : cnt + CW'(1);
        end
        REDUCE: begin
          // cnt counts the two reduction steps (0, then 1).
          c_q <= c_red;
          cnt <= cnt + CW'(1);
          if (cnt[0]) result <= c_red[N-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_multiplier.sv
module tb_montgomery_multiplier;
  localparam int N   = 512;
  localparam int LAT = 515;   // cycles from the sampling edge to the done cycle

  logic         clk = 1'b0;
  logic         resetn, start;
  logic [N-1:0] in_a, in_b, in_m, result;
  logic         done;

  always #5 clk = ~clk;

  montgomery_multiplier #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done)
  );

  localparam logic [N-1:0] NOM_A = 512'hac854dd86a88ee6accefadf4e45af10a3a79e375950c80d43e69d08b5fe850abbd45a7fff952e98e1b90f667ad679a8ef87787575ffe3604bd0d6fcfb0023214;
  localparam logic [N-1:0] NOM_B = 512'hf8ba931ef9df048c6ffe8d55b9992eb451ecccbc655bdaac49429ff67857d747ca5ae7cfcfcc2f38788ba36f4c98fee612fb5c7ed826a51f6e9ce8bbef662beb;
  localparam logic [N-1:0] NOM_M = 512'hc74d7b58ad456f6b6c997b318836afceea0ac62dc83e6c96c40403723ef246a0d30968ef3f7579f0cab0621e4a6bed06c894d20aa809cf347c4377c4ec4cb409;
  localparam logic [N-1:0] NOM_R = 512'h3f869127d962ca1ee7a3e30025438f9a13e884e22346ad294bbb9d5c4491aa217feb11b6b8529c3db9f55d8641bf66b39586d7959545d8ff0379679228f637c3;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: reduce A*B mod M with plain wide arithmetic, then divide by
  // 2^N in the ring (halve N times: x/2 mod M, using M odd).
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    logic [2*N-1:0] p, r;
    logic [N:0]     x;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    r = p % {{N{1'b0}}, m};
    x = r[N:0];
    for (int i = 0; i < N; i++) begin
      if (x[0]) x = x + {1'b0, m};
      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N-1:0] rand_mod();
    logic [N-1:0] r;
    r = rand_word();
    r[0]   = 1'b1;
    r[N-1] = 1'b1;
    return r;
  endfunction

  // Transaction-level model: ph = 0 idle, otherwise cycles since capture.
  int           ph = 0;
  logic         model_live = 1'b0;
  logic [N-1:0] pend, exp_res;

  always @(posedge clk) begin
    model_live = 1'b1;
    if (resetn) begin
      ph      = 0;
      exp_res = '0;
    end else if (ph == 0) begin
      if (start) begin
        pend = mont_ref(in_a, in_b, in_m);
        ph   = 1;
      end
    end else begin
      if (ph == LAT - 1) exp_res = pend;
      ph = (ph == LAT) ? 0 : ph + 1;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("done", N'(done), N'(ph == LAT));
      check("result", result, exp_res);
    end
  end

  // Launch one operation from idle, scramble inputs afterwards, wait for done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                        input int hold, input string name);
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    in_a = rand_word(); in_b = rand_word(); in_m = rand_mod();
    k = 0;
    while (!done && k < 2 * LAT) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, 2 * LAT);
    end else begin
      check({name, "_latency"}, N'(hold + k), N'(LAT));
    end
    @(negedge clk);
  endtask

  initial begin
    int t_done[$];
    logic [N-1:0] ra, rb, rm;

    resetn = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_m = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, '0);
    check("reset_done", N'(done), '0);
    resetn = 1'b0;

    // Pin the model to hand-known values.
    check("pin_nominal", mont_ref(NOM_A, NOM_B, NOM_M), NOM_R);
    check("pin_mersenne", mont_ref(N'(1), N'(1), '1), N'(1));
    check("pin_a_eq_m", mont_ref(NOM_M, NOM_B, NOM_M), '0);

    // Nominal vector, start held two cycles: exactly one done pulse.
    run_op(NOM_A, NOM_B, NOM_M, 2, "nominal");
    check("nominal_literal", result, NOM_R);
    repeat (3) @(negedge clk);

    run_op(N'(1), N'(1), '1, 1, "mersenne");
    check("mersenne_literal", result, N'(1));

    run_op('0, rand_word(), NOM_M, 1, "a_zero");
    check("a_zero_literal", result, '0);
    run_op(NOM_M, rand_word(), NOM_M, 1, "a_eq_m");
    check("a_eq_m_literal", result, '0);
    run_op(rand_word(), '0, NOM_M, 1, "b_zero");
    run_op(rand_word(), '1, NOM_M, 1, "b_ge_m");
    run_op('1, '1, rand_mod(), 1, "all_ones");

    for (int v = 0; v < 6; v++) begin
      ra = rand_word(); rb = rand_word(); rm = rand_mod();
      run_op(ra, rb, rm, 1, "random");
    end

    // Reset 200 cycles into an operation: no done, result cleared.
    @(negedge clk);
    in_a = rand_word(); in_b = rand_word(); in_m = rand_mod(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    check("abort_result", result, '0);
    repeat (LAT + 20) @(negedge clk);   // compare process flags any stray done
    check("abort_result_after", result, '0);
    run_op(NOM_A, NOM_B, NOM_M, 1, "after_abort");
    check("after_abort_literal", result, NOM_R);

    // start held high: back-to-back operations, inputs churn while busy.
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3 * (LAT + 1) + 10; c++) begin
      in_a = rand_word(); in_b = rand_word(); in_m = rand_mod();
      @(negedge clk);
      if (done) t_done.push_back(c);
    end
    start = 1'b0;
    check("stream_pulses", N'(t_done.size()), N'(3));
    for (int i = 1; i < t_done.size(); i++)
      check("stream_period", N'(t_done[i] - t_done[i-1]), N'(LAT + 1));
    repeat (LAT + 10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
